// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Exports the FSM state enum, parameter defaults and a clog2 helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_CNT_WIDTH = 16;

  // Minimum width of 1 so that a single-value counter still has a bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin priority search: first set req_valid bit at or above
// rr_ptr, wrapping. Ports: req_valid, rr_ptr in; found, index out.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [clog2(N_REQ)-1:0] rr_ptr,
  output logic                    found,
  output logic [clog2(N_REQ)-1:0] index
);

  localparam int IW = clog2(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [IW:0]        s;

  // Rotate so bit 0 is rr_ptr; scan downward so the lowest
  // rotated position wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    s     = '0;
    dbl   = {req_valid, req_valid} >> rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        s = {1'b0, rr_ptr} + (IW+1)'(k);
        if (s >= (IW+1)'(N_REQ)) s = s - (IW+1)'(N_REQ);
        found = 1'b1;
        index = s[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port (w_clk domain).
// Ports: req_valid/req_data/req_ready per producer, fifo_full in,
// fifo_wr_en/fifo_data out, grant_valid/grant_id, xfer_count.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int D_WIDTH   = 8,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                    w_clk,
  input  logic                    w_rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*D_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [D_WIDTH-1:0]      fifo_data,
  output logic                    grant_valid,
  output logic [clog2(N_REQ)-1:0] grant_id,
  output logic [CNT_WIDTH-1:0]    xfer_count
);

  localparam int IW = clog2(N_REQ);
  localparam int BW = clog2(MAX_BURST);

  arb_state_t      state;
  logic [IW-1:0]   rr_ptr;
  logic [BW-1:0]   beat_cnt;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            sel_valid;
  logic            last_beat;
  logic [IW-1:0]   next_ptr;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .found     (pick_found),
    .index     (pick_idx)
  );

  // Data is steered even when not writing; no X-gating.
  always_comb begin
    sel_valid = 1'b0;
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        sel_valid = req_valid[i];
        fifo_data = req_data[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign grant_valid = (state == BURST);

  // fifo_full and w_rst gate in the same cycle so a full FIFO or
  // a mid-burst reset never sees or acknowledges a beat.
  assign fifo_wr_en = grant_valid & sel_valid
                    & ~fifo_full & ~w_rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant_valid & ~fifo_full & ~w_rst
                   & (grant_id == IW'(i));
    end
  end

  assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
  assign next_ptr  = (grant_id == IW'(N_REQ - 1)) ?
                     '0 : grant_id + 1'b1;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      xfer_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (!sel_valid) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (fifo_wr_en) begin
            xfer_count <= xfer_count + 1'b1;
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with producer models and
// a write-data scoreboard.
module tb_fifo_wr_arbiter;

  logic        w_clk;
  logic        w_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] xfer_count;

  fifo_wr_arbiter #(
    .N_REQ     (4),
    .D_WIDTH   (8),
    .MAX_BURST (4),
    .CNT_WIDTH (16)
  ) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data   (fifo_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .xfer_count  (xfer_count)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] pmem [4][16];
  int         ph [4];
  int         pt [4];
  logic [3:0] en;
  logic [3:0] take;

  logic [7:0] sb [$];
  int         wcyc [$];
  int         glog [$];
  int         eg [$];
  int         ed [$];
  int         cnum;
  logic       gv_q;
  int         base;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d,
                      input bit exp_wr);
    pmem[i][pt[i] % 16] = d;
    pt[i]++;
    if (exp_wr) sb.push_back(d);
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (en[i] && (pt[i] != ph[i])) begin
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = pmem[i][ph[i] % 16];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge w_clk);
    #3;
  endtask

  task automatic settle();
    refresh();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic drain(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      @(posedge w_clk);
      n++;
    end while (sb.size() != 0 && n < maxc);
    #3;
    chk(tag, sb.size(), 0);
  endtask

  task automatic chk_glog(input string tag);
    chk({tag, "_len"}, glog.size(), eg.size());
    for (int k = 0; k < eg.size(); k++) begin
      chk(tag, (k < glog.size()) ? glog[k] : -1, eg[k]);
    end
  endtask

  task automatic chk_gaps(input string tag);
    chk({tag, "_len"}, wcyc.size(), ed.size() + 1);
    for (int k = 0; k < ed.size(); k++) begin
      chk(tag, (k + 1 < wcyc.size()) ?
          wcyc[k+1] - wcyc[k] : -1, ed[k]);
    end
  endtask

  always @(posedge w_clk) cnum <= cnum + 1;

  // Producers pop a beat after each accepted handshake.
  always @(posedge w_clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (take[i]) ph[i]++;
    end
    refresh();
  end

  always @(negedge w_clk) begin
    logic [31:0] e;
    take = req_valid & req_ready;
    if (grant_valid && !gv_q) glog.push_back(int'(grant_id));
    gv_q = grant_valid;
    chk("ready_onehot", {28'h0, req_ready & ~(grant_valid ?
        (4'b0001 << grant_id) : 4'b0000)}, 0);
    if (fifo_wr_en) begin
      wcyc.push_back(cnum);
      e = 32'hDEAD_0000;
      if (sb.size() != 0) e = {24'h0, sb.pop_front()};
      chk("fifo_data", {24'h0, fifo_data}, e);
    end
  end

  initial begin
    cnum      = 0;
    gv_q      = 1'b0;
    take      = '0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ph[i] = 0;
      pt[i] = 0;
    end

    // Reset with all requesters valid
    w_rst = 1'b1;
    en    = 4'b1111;
    for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    refresh();
    cyc();
    cyc();
    chk("rst_gv", grant_valid, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_xfer", xfer_count, 0);
    w_rst = 1'b0;
    settle();
    chk("rel_gv_pre", grant_valid, 0);
    cyc();
    chk("first_gv", grant_valid, 1);
    chk("first_gid", grant_id, 0);
    drain("rst_drain", 40);
    idle(2);
    chk("rst_xfer_end", xfer_count, 4);
    eg = '{0, 1, 2, 3};
    chk_glog("rst_glog");

    // All four valid continuously
    glog.delete();
    base = int'(xfer_count);
    for (int k = 0; k < 8; k++) push(0, 8'(k), 1'b0);
    for (int k = 0; k < 4; k++) begin
      sb.push_back(8'(k));
    end
    for (int i = 1; i < 4; i++) begin
      for (int k = 0; k < 4; k++) push(i, 8'(i*16 + k), 1'b1);
    end
    for (int k = 4; k < 8; k++) sb.push_back(8'(k));
    refresh();
    drain("all_drain", 80);
    idle(2);
    chk("all_xfer", int'(xfer_count) - base, 20);
    eg = '{0, 1, 2, 3, 0};
    chk_glog("all_glog");

    // Single requester 1 streams 8 beats
    en = 4'b0010;
    glog.delete();
    wcyc.delete();
    base = int'(xfer_count);
    for (int k = 0; k < 8; k++) push(1, 8'h10 + 8'(k), 1'b1);
    refresh();
    drain("one_drain", 60);
    idle(2);
    chk("one_xfer", int'(xfer_count) - base, 8);
    ed = '{1, 1, 1, 2, 1, 1, 1};
    chk_gaps("one_gaps");
    eg = '{1, 1};
    chk_glog("one_glog");

    // fifo_full for 3 cycles after two beats
    en = 4'b0100;
    wcyc.delete();
    base = int'(xfer_count);
    for (int k = 0; k < 5; k++) push(2, 8'h20 + 8'(k), 1'b1);
    refresh();
    cyc();
    chk("full_gid", grant_id, 2);
    cyc();
    cyc();
    fifo_full = 1'b1;
    settle();
    for (int k = 0; k < 3; k++) begin
      chk("full_wr_en", fifo_wr_en, 0);
      chk("full_ready", req_ready, 0);
      chk("full_gv", grant_valid, 1);
      chk("full_gid_hold", grant_id, 2);
      if (k < 2) cyc();
    end
    cyc();
    fifo_full = 1'b0;
    settle();
    drain("full_drain", 40);
    idle(2);
    chk("full_xfer", int'(xfer_count) - base, 5);
    ed = '{1, 4, 1, 2};
    chk_gaps("full_gaps");

    // Requester 2 drops after one beat
    en = 4'b0010;
    push(1, 8'h41, 1'b1);
    refresh();
    drain("pre_drain", 20);
    idle(2);
    en = 4'b1101;
    glog.delete();
    push(2, 8'h52, 1'b1);
    push(3, 8'h53, 1'b1);
    push(3, 8'h63, 1'b1);
    push(0, 8'h50, 1'b1);
    push(0, 8'h60, 1'b1);
    refresh();
    drain("drop_drain", 40);
    idle(2);
    eg = '{2, 3, 0};
    chk_glog("drop_glog");

    // Reset on beat 2 of a burst
    en = 4'b0010;
    glog.delete();
    for (int k = 0; k < 4; k++) push(1, 8'h71 + 8'(k), 1'b0);
    push(0, 8'h80, 1'b0);
    sb.push_back(8'h71);
    refresh();
    cyc();
    chk("mr_gid", grant_id, 1);
    cyc();
    chk("mr_sb", sb.size(), 0);
    w_rst = 1'b1;
    en    = 4'b0011;
    settle();
    chk("mr_wr_en", fifo_wr_en, 0);
    chk("mr_ready", req_ready, 0);
    cyc();
    chk("mr_gv", grant_valid, 0);
    chk("mr_xfer", xfer_count, 0);
    chk("mr_gid_rst", grant_id, 0);
    w_rst = 1'b0;
    glog.delete();
    sb.push_back(8'h80);
    sb.push_back(8'h72);
    sb.push_back(8'h73);
    sb.push_back(8'h74);
    settle();
    drain("mr_drain", 40);
    idle(2);
    chk("mr_xfer_end", xfer_count, 4);
    eg = '{0, 1};
    chk_glog("mr_glog");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the async FIFO among N_REQ producers in the w_clk domain. Each producer presents a valid/ready stream; the arbiter grants one producer at a time for a bounded burst, steers its data onto the FIFO write port and stalls on fifo_full so no beat is ever dropped. It sits between the producer blocks and the FIFO's wr_en/data_in/fifo_full pins and also keeps a running count of accepted writes.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- D_WIDTH, 8: data width, equal to the FIFO data width.
- MAX_BURST, 4: maximum beats per grant, 1..16.
- CNT_WIDTH, 16: width of the write counter.

- w_clk  in  1  write-domain clock.
- w_rst  in  1  reset, synchronous, active-high; clock w_clk.
- req_valid  in  N_REQ  per-requester data valid.
- req_data  in  N_REQ*D_WIDTH  packed data; requester i occupies bits [i*D_WIDTH +: D_WIDTH].
- req_ready  out  N_REQ  per-requester accept; a beat transfers when valid and ready are both 1 at a w_clk edge.
- fifo_full  in  1  FIFO full flag (w_clk domain).
- fifo_wr_en  out  1  FIFO write enable.
- fifo_data  out  D_WIDTH  FIFO write data.
- grant_valid  out  1  a requester currently holds the grant.
- grant_id  out  clog2(N_REQ)  index of the granted requester.
- xfer_count  out  CNT_WIDTH  total beats written since reset; wraps modulo 2^CNT_WIDTH.

## Operation
- States: IDLE and BURST. Registers: state, grant_id, rr_ptr, beat_cnt, xfer_count.
- IDLE: if any req_valid is high, pick the first valid index searching upward from rr_ptr, wrapping modulo N_REQ. Load grant_id, clear beat_cnt and go to BURST. No writes occur in IDLE, and all req_ready bits are 0.
- BURST: req_ready[grant_id] = ~fifo_full. All other ready bits are 0. fifo_wr_en = req_valid[grant_id] & ~fifo_full. fifo_data = the req_data slice selected by grant_id. These outputs are combinational from registered grant and inputs.
- On each transfer, beat_cnt and xfer_count each increment by 1.
- The burst ends and the arbiter returns to IDLE when either of these happens:
  - A transfer occurs with beat_cnt == MAX_BURST-1.
  - req_valid[grant_id] is 0. No beat transfers in that cycle.
- On burst end, rr_ptr <= (grant_id+1) mod N_REQ.
- fifo_full during BURST: the grant is held, no transfer occurs, and beat_cnt is frozen. A full FIFO never ends a burst.
- fifo_data is don't-care when fifo_wr_en is 0. It is driven from the selected slice anyway and is never X-gated.

## Timing
- Reset values: state IDLE, grant_valid 0, grant_id 0, rr_ptr 0, beat_cnt 0, xfer_count 0, req_ready 0, fifo_wr_en 0.
- While w_rst is 1, fifo_wr_en and req_ready are forced to 0 in that same cycle, including a reset asserted mid-burst. The in-flight beat is not written and is not acknowledged.
- Grant latency: valid seen at edge t in IDLE gives grant_valid=1 after edge t. The first beat can transfer at edge t+1.
- Handover costs exactly one IDLE cycle between bursts, so maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- fifo_full is used combinationally in the same cycle. This is mandatory because the FIFO discards writes when full.
- A requester may change req_data only after a transfer or while its req_valid is 0.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - the MAX_BURST and CNT_WIDTH defaults;
  - a clog2 helper for the grant_id and beat_cnt widths.
- Sub-module rr_picker: combinational round-robin priority search. Inputs are req_valid and rr_ptr; outputs are found and index. It is instantiated once in the IDLE decision.

## Test plan
- Reset: hold w_rst for 2 cycles with all req_valid=1 -> grant_valid=0, fifo_wr_en=0, req_ready=0, xfer_count=0. First grant goes to requester 0 one cycle after release.
- Single requester 1 streams 0x10..0x17 continuously -> FIFO receives 0x10..0x17 in order as two 4-beat bursts with one idle cycle between them; xfer_count=8.
- All four requesters valid continuously -> grant_id sequence 0,1,2,3,0, each with 4 beats; each burst's data comes only from the granted requester.
- fifo_full raised for 3 cycles after beat 2 of a burst -> fifo_wr_en=0, req_ready=0 and grant held for those 3 cycles. Beats 3 and 4 follow on release, and no data is lost or duplicated.
- Requester 2 drops req_valid after 1 beat while 0 and 3 are valid -> burst ends with beat_cnt=1. rr_ptr=3, and the next grant goes to 3, then 0.
- w_rst asserted on beat 2 of a burst -> no write on that edge; state IDLE and xfer_count=0 afterwards. Re-arbitration starts at requester 0.
